vga_timing_gen: RTL and testbench

//  Generates VGA raster timing: free-running column/row counters, HSync/VSync pulses with porches, active-video flag, and frame/line start ticks.

---
 rtl/vga_timing_gen_pkg.sv | 34 +++
 rtl/vga_timing_gen_if.sv | 34 +++
 rtl/vga_timing_gen_delay_line.sv | 32 +++
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz-class pixel clock.
package vga_timing_gen_pkg;

    localparam int   COORD_W           = 10;
    localparam int   RGB_W             = 4;
    localparam int   BUNDLE_W          = 3 + 3 * RGB_W;

    localparam int   DEF_TOTAL_COLS    = 800;
    localparam int   DEF_TOTAL_ROWS    = 525;
    localparam int   DEF_ACTIVE_COLS   = 640;
    localparam int   DEF_ACTIVE_ROWS   = 480;
    localparam int   DEF_H_FRONT_PORCH = 18;
    localparam int   DEF_H_SYNC_WIDTH  = 92;
    localparam int   DEF_V_FRONT_PORCH = 10;
    localparam int   DEF_V_SYNC_WIDTH  = 2;
    localparam logic DEF_SYNC_ACTIVE   = 1'b0;
    localparam int   DEF_VIDEO_DELAY   = 2;

    // Sync level for a coordinate: asserted inside [start, stop), idle elsewhere.
    function automatic logic sync_level(input logic [COORD_W-1:0] pos,
                                        input logic [COORD_W-1:0] start,
                                        input logic [COORD_W-1:0] stop,
                                        input logic               act_lvl);
        logic in_win_s;
        in_win_s = (pos >= start) && (pos < stop);
        if (in_win_s) begin
            return act_lvl;
        end else begin
            return ~act_lvl;
        end
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing and video bus between the timing generator (master),
// the renderer and the VGA pins.
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    logic [COORD_W-1:0] col_count;
    logic [COORD_W-1:0] row_count;
    logic               hsync;
    logic               vsync;
    logic               active;
    logic               frame_start;
    logic               line_start;
    logic [RGB_W-1:0]   red_video;
    logic [RGB_W-1:0]   grn_video;
    logic [RGB_W-1:0]   blu_video;
    logic               vga_hsync;
    logic               vga_vsync;
    logic [RGB_W-1:0]   vga_red;
    logic [RGB_W-1:0]   vga_grn;
    logic [RGB_W-1:0]   vga_blu;

    modport master (
        output col_count, row_count, hsync, vsync, active, frame_start, line_start,
        input  red_video, grn_video, blu_video,
        output vga_hsync, vga_vsync, vga_red, vga_grn, vga_blu
    );

    modport slave (
        input  col_count, row_count, hsync, vsync, active, frame_start, line_start,
        output red_video, grn_video, blu_video,
        input  vga_hsync, vga_vsync, vga_red, vga_grn, vga_blu
    );

endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// Fixed-latency shift register with a per-instance reset pattern, used to
// keep pin-level sync and pixel data aligned.
module vga_delay_line #(
    parameter int               WIDTH     = 15,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift one stage per clock; reset flushes every stage to RESET_VAL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= RESET_VAL;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running column/row counters, sync pulses,
// active flag, start ticks, and a fixed-delay re-timing of renderer RGB.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   TOTAL_COLS    = DEF_TOTAL_COLS,
    parameter int   TOTAL_ROWS    = DEF_TOTAL_ROWS,
    parameter int   ACTIVE_COLS   = DEF_ACTIVE_COLS,
    parameter int   ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
    parameter int   H_FRONT_PORCH = DEF_H_FRONT_PORCH,
    parameter int   H_SYNC_WIDTH  = DEF_H_SYNC_WIDTH,
    parameter int   V_FRONT_PORCH = DEF_V_FRONT_PORCH,
    parameter int   V_SYNC_WIDTH  = DEF_V_SYNC_WIDTH,
    parameter logic SYNC_ACTIVE   = DEF_SYNC_ACTIVE,
    parameter int   VIDEO_DELAY   = DEF_VIDEO_DELAY
) (
    input  logic            i_Clk,
    input  logic            i_Rst_L,
    vga_timing_gen_if.master vga
);

    if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) begin : g_bad_h
        $error("vga_timing_gen: horizontal active+porch+sync exceeds TOTAL_COLS");
    end
    if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) begin : g_bad_v
        $error("vga_timing_gen: vertical active+porch+sync exceeds TOTAL_ROWS");
    end
    if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024) begin : g_bad_size
        $error("vga_timing_gen: totals do not fit the 10-bit counters");
    end
    if (VIDEO_DELAY < 1 || VIDEO_DELAY > 4) begin : g_bad_delay
        $error("vga_timing_gen: VIDEO_DELAY must be 1..4");
    end

    localparam logic [COORD_W-1:0] COL_LAST = 10'(TOTAL_COLS - 1);
    localparam logic [COORD_W-1:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
    localparam logic [COORD_W-1:0] ACT_COLS = 10'(ACTIVE_COLS);
    localparam logic [COORD_W-1:0] ACT_ROWS = 10'(ACTIVE_ROWS);
    localparam logic [COORD_W-1:0] HS_START = 10'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [COORD_W-1:0] HS_STOP  = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [COORD_W-1:0] VS_START = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [COORD_W-1:0] VS_STOP  = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);
    localparam logic [BUNDLE_W-1:0] PIPE_IDLE = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0, 12'h000};

    logic [COORD_W-1:0]  col_r, row_r;
    logic [COORD_W-1:0]  col_nxt_s, row_nxt_s;
    logic                started_r;
    logic                hsync_r, vsync_r, active_r, frame_start_r, line_start_r;
    logic [BUNDLE_W-1:0] bundle_in_s, bundle_out_s;
    logic                act_dly_s;

    // Next raster position; the first cycle after reset holds (0,0) so the
    // first counted pixel carries its frame/line ticks.
    always_comb begin
        col_nxt_s = 10'd0;
        row_nxt_s = row_r;
        if (!started_r) begin
            col_nxt_s = 10'd0;
            row_nxt_s = 10'd0;
        end else if (col_r == COL_LAST) begin
            col_nxt_s = 10'd0;
            if (row_r == ROW_LAST) begin
                row_nxt_s = 10'd0;
            end else begin
                row_nxt_s = row_r + 10'd1;
            end
        end else begin
            col_nxt_s = col_r + 10'd1;
            row_nxt_s = row_r;
        end
    end

    // Counters and decodes registered together so they always agree.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            started_r     <= 1'b0;
            col_r         <= 10'd0;
            row_r         <= 10'd0;
            hsync_r       <= ~SYNC_ACTIVE;
            vsync_r       <= ~SYNC_ACTIVE;
            active_r      <= 1'b0;
            frame_start_r <= 1'b0;
            line_start_r  <= 1'b0;
        end else begin
            started_r     <= 1'b1;
            col_r         <= col_nxt_s;
            row_r         <= row_nxt_s;
            hsync_r       <= sync_level(col_nxt_s, HS_START, HS_STOP, SYNC_ACTIVE);
            vsync_r       <= sync_level(row_nxt_s, VS_START, VS_STOP, SYNC_ACTIVE);
            active_r      <= (col_nxt_s < ACT_COLS) && (row_nxt_s < ACT_ROWS);
            frame_start_r <= (col_nxt_s == 10'd0) && (row_nxt_s == 10'd0);
            line_start_r  <= (col_nxt_s == 10'd0);
        end
    end

    assign bundle_in_s = {hsync_r, vsync_r, active_r, vga.red_video, vga.grn_video, vga.blu_video};

    vga_delay_line #(
        .WIDTH     (BUNDLE_W),
        .DEPTH     (VIDEO_DELAY),
        .RESET_VAL (PIPE_IDLE)
    ) u_delay (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .d     (bundle_in_s),
        .q     (bundle_out_s)
    );

    assign act_dly_s = bundle_out_s[12];

    assign vga.col_count   = col_r;
    assign vga.row_count   = row_r;
    assign vga.hsync       = hsync_r;
    assign vga.vsync       = vsync_r;
    assign vga.active      = active_r;
    assign vga.frame_start = frame_start_r;
    assign vga.line_start  = line_start_r;
    assign vga.vga_hsync   = bundle_out_s[14];
    assign vga.vga_vsync   = bundle_out_s[13];
    // Blanking is one AND gate behind the last flop, keyed by the pixel's own delayed active bit.
    assign vga.vga_red     = act_dly_s ? bundle_out_s[11:8] : 4'd0;
    assign vga.vga_grn     = act_dly_s ? bundle_out_s[7:4]  : 4'd0;
    assign vga.vga_blu     = act_dly_s ? bundle_out_s[3:0]  : 4'd0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default 640x480 instance plus a
// tiny-raster instance (positive sync, delay 3) that reaches VSync and wraps.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       hs, vs, act, fs, ls, vhs, vvs;
        logic [3:0] vr, vg, vb;
    } obs_t;

    // Per-instance timing constants: [0] default raster, [1] tiny raster.
    int   P_TC [2] = '{800, 20};
    int   P_TR [2] = '{525, 12};
    int   P_AC [2] = '{640, 12};
    int   P_AR [2] = '{480, 8};
    int   P_H0 [2] = '{658, 14};
    int   P_H1 [2] = '{750, 17};
    int   P_V0 [2] = '{490, 9};
    int   P_V1 [2] = '{492, 11};
    int   P_D  [2] = '{2, 3};
    logic P_SA [2] = '{1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] d_r, d_g, d_b;
    int checks = 0;
    int errors = 0;

    obs_t q0[$];
    obs_t q1[$];
    obs_t m_vis [2];
    logic [14:0] m_pipe [2][4];
    logic m_started [2];

    always #5 clk = ~clk;

    vga_timing_gen_if bus0 ();
    vga_timing_gen_if bus1 ();

    assign bus0.red_video = d_r;
    assign bus0.grn_video = d_g;
    assign bus0.blu_video = d_b;
    assign bus1.red_video = d_r;
    assign bus1.grn_video = d_g;
    assign bus1.blu_video = d_b;

    vga_timing_gen dut0 (.i_Clk(clk), .i_Rst_L(rst_n), .vga(bus0));

    vga_timing_gen #(
        .TOTAL_COLS(20), .TOTAL_ROWS(12), .ACTIVE_COLS(12), .ACTIVE_ROWS(8),
        .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2),
        .SYNC_ACTIVE(1'b1), .VIDEO_DELAY(3)
    ) dut1 (.i_Clk(clk), .i_Rst_L(rst_n), .vga(bus1));

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, req, $time);
        end
    endtask

    // Reference model: what instance k shows after a rising edge.
    task automatic step(input int k, input logic rst, input logic [11:0] rgb, output obs_t o);
        obs_t v, n;
        logic [14:0] blank, e;
        int c, r;
        v = m_vis[k];
        n = '0;
        blank = {~P_SA[k], ~P_SA[k], 1'b0, 12'h000};
        if (!rst) begin
            for (int i = 0; i < 4; i++) m_pipe[k][i] = blank;
            m_started[k] = 1'b0;
            c = 0;
            r = 0;
            n.act = 1'b0;
            n.fs = 1'b0;
            n.ls = 1'b0;
            n.hs = ~P_SA[k];
            n.vs = ~P_SA[k];
        end else begin
            e = {v.hs, v.vs, v.act, rgb};
            for (int i = 3; i > 0; i--) m_pipe[k][i] = m_pipe[k][i-1];
            m_pipe[k][0] = e;
            c = int'(v.col);
            r = int'(v.row);
            if (!m_started[k]) begin
                c = 0;
                r = 0;
                m_started[k] = 1'b1;
            end else begin
                c = c + 1;
                if (c == P_TC[k]) begin
                    c = 0;
                    r = r + 1;
                    if (r == P_TR[k]) r = 0;
                end
            end
            n.act = (c < P_AC[k]) && (r < P_AR[k]);
            n.hs  = (c >= P_H0[k] && c < P_H1[k]) ? P_SA[k] : ~P_SA[k];
            n.vs  = (r >= P_V0[k] && r < P_V1[k]) ? P_SA[k] : ~P_SA[k];
            n.fs  = (c == 0) && (r == 0);
            n.ls  = (c == 0);
        end
        n.col = 10'(c);
        n.row = 10'(r);
        e = m_pipe[k][P_D[k]-1];
        n.vhs = e[14];
        n.vvs = e[13];
        n.vr  = e[12] ? e[11:8] : 4'd0;
        n.vg  = e[12] ? e[7:4]  : 4'd0;
        n.vb  = e[12] ? e[3:0]  : 4'd0;
        m_vis[k] = n;
        o = n;
    endtask

    task automatic sb_compare(input int k, input obs_t got, input obs_t req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL scoreboard dut%0d t=%0t: got %h (col=%0d row=%0d), required %h (col=%0d row=%0d)",
                     k, $time, got, got.col, got.row, req, req.col, req.row);
        end
    endtask

    // Stimulus side of the scoreboard: predict every cycle at the active edge.
    initial begin
        obs_t o;
        forever begin
            @(posedge clk);
            step(0, rst_n, {d_r, d_g, d_b}, o);
            q0.push_back(o);
            step(1, rst_n, {d_r, d_g, d_b}, o);
            q1.push_back(o);
        end
    end

    // Monitor: pop and compare on the opposite edge.
    initial begin
        obs_t a;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                a = {bus0.col_count, bus0.row_count, bus0.hsync, bus0.vsync, bus0.active,
                     bus0.frame_start, bus0.line_start, bus0.vga_hsync, bus0.vga_vsync,
                     bus0.vga_red, bus0.vga_grn, bus0.vga_blu};
                sb_compare(0, a, q0.pop_front());
            end
            if (q1.size() > 0) begin
                a = {bus1.col_count, bus1.row_count, bus1.hsync, bus1.vsync, bus1.active,
                     bus1.frame_start, bus1.line_start, bus1.vga_hsync, bus1.vga_vsync,
                     bus1.vga_red, bus1.vga_grn, bus1.vga_blu};
                sb_compare(1, a, q1.pop_front());
            end
        end
    end

    // Directed stimulus plus hand-computed spot checks.
    initial begin
        int hs_cnt, hs_first, hs_last, ls_cnt, act_fall, fs_cnt, fs_n0, fs_n1;
        int dly0_bad, dly1_bad, found;
        logic prev_act;
        logic [2:0] hs0_hist;
        logic [2:0] hs1_hist;

        rst_n = 1'b0;
        d_r = 4'h0; d_g = 4'h0; d_b = 4'h0;
        hs_cnt = 0; hs_first = -1; hs_last = -1; ls_cnt = 0; act_fall = -1;
        fs_cnt = 0; fs_n0 = -1; fs_n1 = -1; dly0_bad = 0; dly1_bad = 0;
        prev_act = 1'b0; hs0_hist = 3'b111; hs1_hist = 3'b000;

        // Reset held for 5 clocks; check reset values in the middle.
        repeat (2) @(negedge clk);
        chk("rst_col", int'(bus0.col_count), 0);
        chk("rst_hsync", int'(bus0.hsync), 1);
        chk("rst_active", int'(bus0.active), 0);
        chk("rst_frame_start", int'(bus0.frame_start), 0);
        chk("rst_vga_hsync", int'(bus0.vga_hsync), 1);
        chk("rst_vga_red", int'(bus0.vga_red), 0);
        chk("rst_small_hsync", int'(bus1.hsync), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_col", int'(bus0.col_count), 0);
        chk("first_row", int'(bus0.row_count), 0);
        chk("first_frame_start", int'(bus0.frame_start), 1);
        chk("first_active", int'(bus0.active), 1);

        // Three default lines (many tiny frames) with random and directed RGB.
        for (int n = 0; n < 2400; n++) begin
            if (bus0.row_count == 10'd0) begin
                if (bus0.hsync == 1'b0) begin
                    if (hs_first < 0) hs_first = int'(bus0.col_count);
                    hs_last = int'(bus0.col_count);
                    hs_cnt++;
                end
                if (bus0.line_start) ls_cnt++;
                if (prev_act && !bus0.active && act_fall < 0) act_fall = int'(bus0.col_count);
            end
            prev_act = bus0.active;
            if (bus1.frame_start) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_n0 = n;
                if (fs_cnt == 2) fs_n1 = n;
            end
            if (n >= 2 && bus0.vga_hsync != hs0_hist[1]) dly0_bad++;
            if (n >= 3 && bus1.vga_hsync != hs1_hist[2]) dly1_bad++;
            hs0_hist = {hs0_hist[1:0], bus0.hsync};
            hs1_hist = {hs1_hist[1:0], bus1.hsync};
            if (bus0.row_count == 10'd0 && bus0.col_count == 10'd12) begin
                chk("rgb_col10_red", int'(bus0.vga_red), 15);
                chk("rgb_col10_grn", int'(bus0.vga_grn), 5);
                chk("rgb_col10_blu", int'(bus0.vga_blu), 10);
            end
            if (bus0.row_count == 10'd1 && bus0.col_count == 10'd702) begin
                chk("rgb_col700_red", int'(bus0.vga_red), 0);
                chk("rgb_col700_grn", int'(bus0.vga_grn), 0);
                chk("rgb_col700_blu", int'(bus0.vga_blu), 0);
            end
            if ((bus0.row_count == 10'd0 && bus0.col_count == 10'd10) ||
                (bus0.row_count == 10'd1 && bus0.col_count == 10'd700)) begin
                d_r = 4'hF; d_g = 4'h5; d_b = 4'hA;
            end else begin
                d_r = 4'($urandom_range(0, 15));
                d_g = 4'($urandom_range(0, 15));
                d_b = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
        end
        chk("hsync_low_count", hs_cnt, 92);
        chk("hsync_first_col", hs_first, 658);
        chk("hsync_last_col", hs_last, 749);
        chk("line_start_count", ls_cnt, 1);
        chk("active_fall_col", act_fall, 640);
        chk("small_frame_length", fs_n1 - fs_n0, 240);
        chk("vga_hsync_delay2", dly0_bad, 0);
        chk("vga_hsync_delay3_small", dly1_bad, 0);

        // Mid-frame reset for one clock at col 400.
        found = 0;
        for (int n = 0; n < 1000 && found == 0; n++) begin
            if (bus0.col_count == 10'd400) found = 1;
            else @(negedge clk);
        end
        chk("wait_col400", found, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_col", int'(bus0.col_count), 0);
        chk("midrst_row", int'(bus0.row_count), 0);
        chk("midrst_vga_hsync", int'(bus0.vga_hsync), 1);
        chk("midrst_vga_red", int'(bus0.vga_red), 0);
        @(negedge clk);
        chk("resume_frame_start", int'(bus0.frame_start), 1);
        for (int n = 0; n < 1000; n++) begin
            d_r = 4'($urandom_range(0, 15));
            d_g = 4'($urandom_range(0, 15));
            d_b = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        chk("resume_col", int'(bus0.col_count), 200);
        chk("resume_row", int'(bus0.row_count), 1);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
